// File: rtl/receiver_regmap_mc_if.sv
// AXI-lite bundle (32-bit data) for the receiver register map.
interface receiver_regmap_mc_if #(
  parameter int ADDRESS_WIDTH = 11
);
  logic                     awvalid, awready;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic                     wvalid, wready;
  logic [31:0]              wdata;
  logic [3:0]               wstrb;
  logic                     bvalid, bready;
  logic [1:0]               bresp;
  logic                     arvalid, arready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic                     rvalid, rready;
  logic [31:0]              rdata;
  logic [1:0]               rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/receiver_regmap_mc.sv
// Multi-channel receiver status/control register map on an AXI-lite slave.
// Per-channel sync counters and IRQ status bits live in receiver_regmap_mc_ch.
module receiver_regmap_mc_ch #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 sync_event,
  input  logic                 cnt_clr,
  input  logic                 st_clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 st
);
  // a sync event wins over a same-cycle clear in both the counter and the status bit
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt <= '0;
      st  <= 1'b0;
    end else begin
      if (cnt_clr)                       cnt <= sync_event ? CNT_WIDTH'(1) : '0;
      else if (sync_event && cnt != '1)  cnt <= cnt + 1'b1;
      if (sync_event)   st <= 1'b1;
      else if (st_clr)  st <= 1'b0;
    end
  end
endmodule

module receiver_regmap_mc #(
  parameter logic [31:0] ID            = 32'd0,
  parameter int          ADDRESS_WIDTH = 11,
  parameter int          N_CH          = 2,
  parameter int          CNT_WIDTH     = 16,
  localparam int         N_id_MAX      = 1007,
  localparam int         NID_W         = $clog2(N_id_MAX)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  receiver_regmap_mc_if.slave     s_axi_if,
  input  logic [2*N_CH-1:0]       fs_state_i,
  input  logic [2*N_CH-1:0]       N_id_2_i,
  input  logic [NID_W*N_CH-1:0]   N_id_i,
  input  logic [N_CH-1:0]         sync_event_i,
  output logic [31:0]             ctrl_o,
  output logic                    irq_o
);
  localparam int WA = ADDRESS_WIDTH - 2;
  typedef logic [WA-1:0] word_t;

  localparam logic [31:0] VERSION = 32'h0005_0000;
  localparam logic [31:0] MAGIC   = 32'h5258_7E7E;

  typedef enum logic [1:0] {R_RST, R_IDLE, R_CAPT, R_DATA} rd_st_t;
  typedef enum logic [2:0] {W_RST, W_IDLE, W_AW, W_W, W_BOTH, W_RESP} wr_st_t;

  rd_st_t rd_q, rd_d;
  wr_st_t wr_q, wr_d;
  logic   rd_cap, wr_en;

  word_t       ar_word_q, aw_word_q;
  logic [31:0] wdata_q, rdata_q, rd_mux;
  logic [31:0] scratch_q, ctrl_q;
  logic [N_CH-1:0] mask_q, irq_st, cnt_clr, w1c;
  logic [N_CH-1:0][CNT_WIDTH-1:0] cnt;

  // ---------------- read FSM ----------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rd_q <= R_RST;
    else           rd_q <= rd_d;
  end

  always_comb begin
    rd_d = rd_q;
    case (rd_q)
      R_RST:  rd_d = R_IDLE;
      R_IDLE: if (s_axi_if.arvalid) rd_d = R_CAPT;
      R_CAPT: rd_d = R_DATA;
      R_DATA: if (s_axi_if.rready) rd_d = R_IDLE;
      default: rd_d = R_RST;
    endcase
  end

  always_comb begin
    s_axi_if.arready = (rd_q == R_IDLE);
    s_axi_if.rvalid  = (rd_q == R_DATA);
    rd_cap           = (rd_q == R_CAPT);
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) wr_q <= W_RST;
    else           wr_q <= wr_d;
  end

  always_comb begin
    wr_d = wr_q;
    case (wr_q)
      W_RST:  wr_d = W_IDLE;
      W_IDLE: begin
        if (s_axi_if.awvalid && s_axi_if.wvalid) wr_d = W_BOTH;
        else if (s_axi_if.awvalid)               wr_d = W_AW;
        else if (s_axi_if.wvalid)                wr_d = W_W;
      end
      W_AW:   if (s_axi_if.wvalid)  wr_d = W_BOTH;
      W_W:    if (s_axi_if.awvalid) wr_d = W_BOTH;
      W_BOTH: wr_d = W_RESP;
      W_RESP: if (s_axi_if.bready) wr_d = W_IDLE;
      default: wr_d = W_RST;
    endcase
  end

  always_comb begin
    s_axi_if.awready = (wr_q == W_IDLE) || (wr_q == W_W);
    s_axi_if.wready  = (wr_q == W_IDLE) || (wr_q == W_AW);
    s_axi_if.bvalid  = (wr_q == W_RESP);
    wr_en            = (wr_q == W_BOTH);
  end

  assign s_axi_if.bresp = 2'b00;
  assign s_axi_if.rresp = 2'b00;
  assign s_axi_if.rdata = rdata_q;

  // ---------------- address / data capture ----------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ar_word_q <= '0;
      aw_word_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (s_axi_if.arvalid && s_axi_if.arready) ar_word_q <= s_axi_if.araddr[ADDRESS_WIDTH-1:2];
      if (s_axi_if.awvalid && s_axi_if.awready) aw_word_q <= s_axi_if.awaddr[ADDRESS_WIDTH-1:2];
      if (s_axi_if.wvalid  && s_axi_if.wready)  wdata_q   <= s_axi_if.wdata;
      if (rd_cap)                               rdata_q   <= rd_mux;
    end
  end

  // ---------------- RW registers ----------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      scratch_q <= '0;
      ctrl_q    <= '0;
      mask_q    <= '0;
      ctrl_o    <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (aw_word_q)
          word_t'(4): scratch_q <= wdata_q;
          word_t'(5): ctrl_q    <= wdata_q;
          word_t'(6): mask_q    <= wdata_q[N_CH-1:0];
          default: ;
        endcase
      end
      ctrl_o <= ctrl_q;
      irq_o  <= |(irq_st & mask_q);
    end
  end

  assign w1c = (wr_en && aw_word_q == word_t'(7)) ? wdata_q[N_CH-1:0] : '0;

  // ---------------- per-channel state ----------------
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign cnt_clr[c] = rd_cap && (ar_word_q == word_t'(16 + 4*c + 3));

    receiver_regmap_mc_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .sync_event (sync_event_i[c]),
      .cnt_clr    (cnt_clr[c]),
      .st_clr     (w1c[c]),
      .cnt        (cnt[c]),
      .st         (irq_st[c])
    );
  end

  // ---------------- read mux ----------------
  // channel c occupies words 0x10+4c .. 0x13+4c; anything unmatched reads 0
  always_comb begin
    rd_mux = '0;
    case (ar_word_q)
      word_t'(0): rd_mux = VERSION;
      word_t'(1): rd_mux = ID;
      word_t'(2): rd_mux = 32'(N_CH);
      word_t'(3): rd_mux = MAGIC;
      word_t'(4): rd_mux = scratch_q;
      word_t'(5): rd_mux = ctrl_q;
      word_t'(6): rd_mux = 32'(mask_q);
      word_t'(7): rd_mux = 32'(irq_st);
      default: ;
    endcase
    for (int c = 0; c < N_CH; c++) begin
      if (ar_word_q == word_t'(16 + 4*c))     rd_mux = 32'(fs_state_i[2*c +: 2]);
      if (ar_word_q == word_t'(16 + 4*c + 1)) rd_mux = 32'(N_id_2_i[2*c +: 2]);
      if (ar_word_q == word_t'(16 + 4*c + 2)) rd_mux = 32'(N_id_i[NID_W*c +: NID_W]);
      if (ar_word_q == word_t'(16 + 4*c + 3)) rd_mux = 32'(cnt[c]);
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_if.wstrb, s_axi_if.awaddr[1:0], s_axi_if.araddr[1:0]};
endmodule

// File: tb/tb_receiver_regmap_mc.sv
// Directed bench for receiver_regmap_mc: ID=5, N_CH=2, CNT_WIDTH=4.
module tb_receiver_regmap_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_ni;
  logic [3:0]  fs_state_i, N_id_2_i;
  logic [19:0] N_id_i;
  logic [1:0]  sync_event_i;
  logic [31:0] ctrl_o;
  logic        irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  receiver_regmap_mc_if #(.ADDRESS_WIDTH(11)) axi ();

  receiver_regmap_mc #(.ID(32'd5), .ADDRESS_WIDTH(11), .N_CH(2), .CNT_WIDTH(4)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .s_axi_if     (axi),
    .fs_state_i   (fs_state_i),
    .N_id_2_i     (N_id_2_i),
    .N_id_i       (N_id_i),
    .sync_event_i (sync_event_i),
    .ctrl_o       (ctrl_o),
    .irq_o        (irq_o)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [10:0] a, input logic [31:0] d, output logic [1:0] resp);
    logic aw_hs, w_hs;
    int n = 0;
    axi.awaddr = a; axi.wdata = d; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    while ((axi.awvalid || axi.wvalid) && n < 50) begin
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      tick(); n++;
      if (aw_hs) axi.awvalid = 1'b0;
      if (w_hs)  axi.wvalid  = 1'b0;
    end
    while (!axi.bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL write_timeout addr=%h: no bvalid within 50 cycles", a);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; resp = 2'b11;
      return;
    end
    resp = axi.bresp;
    axi.bready = 1'b1; tick(); axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [10:0] a, output logic [31:0] d, output int lat);
    int n = 0;
    axi.araddr = a; axi.arvalid = 1'b1;
    while (!axi.arready && n < 50) begin tick(); n++; end
    tick(); axi.arvalid = 1'b0;
    lat = 0;
    while (!axi.rvalid && lat < 50) begin tick(); lat++; end
    if (n >= 50 || lat >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL read_timeout addr=%h", a);
      d = 'x;
      return;
    end
    d = axi.rdata;
    axi.rready = 1'b1; tick(); axi.rready = 1'b0;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, axi.rdata, ctrl_o, irq_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got aw%b w%b ar%b b%b r%b rdata=%h ctrl=%h irq=%b, required all 0",
               axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, axi.rdata, ctrl_o, irq_o);
    end
    @(negedge clk); reset_ni = 1'b1; #1;
    n_checks++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b000) begin
      n_fail++; $display("FAIL ready_before_edge: got %b required 000", {axi.awready, axi.wready, axi.arready});
    end
    tick();
    n_checks++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
      n_fail++; $display("FAIL ready_after_edge: got %b required 111", {axi.awready, axi.wready, axi.arready});
    end
  endtask

  task automatic test_id_regs();
    logic [31:0] d; int lat;
    axi_read(11'h000, d, lat);
    n_checks++; if (d !== 32'h0005_0000) begin n_fail++; $display("FAIL version: got %h required 00050000", d); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL read_latency: got %0d required 1", lat); end
    axi_read(11'h004, d, lat);
    n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL id: got %h required 5", d); end
    axi_read(11'h008, d, lat);
    n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL n_ch: got %h required 2", d); end
    axi_read(11'h00C, d, lat);
    n_checks++; if (d !== 32'h5258_7E7E) begin n_fail++; $display("FAIL magic: got %h required 52587e7e", d); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL read_latency2: got %0d required 1", lat); end
  endtask

  task automatic test_ctrl_w_first();
    logic [31:0] d; int lat;
    axi.wdata = 32'hDEAD_BEEF; axi.wvalid = 1'b1; axi.awaddr = 11'h014; axi.awvalid = 1'b0;
    tick(); axi.wvalid = 1'b0;
    n_checks++; if (axi.wready !== 1'b0) begin n_fail++; $display("FAIL wready_drop: got %b required 0", axi.wready); end
    repeat (2) tick();
    axi.awvalid = 1'b1;
    tick(); axi.awvalid = 1'b0;
    n_checks++; if (axi.bvalid !== 1'b0) begin n_fail++; $display("FAIL bvalid_early: got %b required 0", axi.bvalid); end
    tick();
    n_checks++; if (axi.bvalid !== 1'b1) begin n_fail++; $display("FAIL bvalid_timing: got %b required 1", axi.bvalid); end
    n_checks++; if (ctrl_o !== 32'h0) begin n_fail++; $display("FAIL ctrl_o_lag: got %h required 0", ctrl_o); end
    axi.bready = 1'b1; tick(); axi.bready = 1'b0;
    n_checks++; if (ctrl_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ctrl_o: got %h required deadbeef", ctrl_o); end
    n_checks++;
    if ({axi.awready, axi.wready} !== 2'b11) begin n_fail++; $display("FAIL aw_w_reassert: got %b required 11", {axi.awready, axi.wready}); end
    axi_read(11'h014, d, lat);
    n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ctrl_readback: got %h required deadbeef", d); end
  endtask

  task automatic test_ro_discard();
    logic [31:0] d; int lat; logic [1:0] r;
    axi_write(11'h000, 32'hFFFF_FFFF, r);
    n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL ro_bresp: got %b required 00", r); end
    axi_read(11'h000, d, lat);
    n_checks++; if (d !== 32'h0005_0000) begin n_fail++; $display("FAIL ro_version: got %h required 00050000", d); end
    axi_write(11'h080, 32'h1234_5678, r);
    n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL unmapped_bresp: got %b required 00", r); end
    axi_read(11'h080, d, lat);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h required 0", d); end
    axi_read(11'h060, d, lat);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL past_last_ch: got %h required 0", d); end
  endtask

  task automatic test_status_inputs();
    logic [31:0] d; int lat;
    logic [10:0] addrs [6] = '{11'h040, 11'h044, 11'h048, 11'h050, 11'h054, 11'h058};
    logic [31:0] exps  [6] = '{32'd1, 32'd2, 32'd300, 32'd2, 32'd1, 32'd1007};
    fs_state_i = {2'd2, 2'd1}; N_id_2_i = {2'd1, 2'd2}; N_id_i = {10'd1007, 10'd300};
    for (int i = 0; i < 6; i++) begin
      axi_read(addrs[i], d, lat);
      n_checks++;
      if (d !== exps[i]) begin n_fail++; $display("FAIL status_%h: got %h required %h", addrs[i], d, exps[i]); end
    end
  endtask

  task automatic test_sync_cnt();
    logic [31:0] d; int lat;
    for (int i = 0; i < 20; i++) begin
      sync_event_i = 2'b10; tick(); sync_event_i = 2'b00; tick();
    end
    axi_read(11'h05C, d, lat);
    n_checks++; if (d !== 32'd15) begin n_fail++; $display("FAIL cnt_saturate: got %h required 15", d); end
    axi_read(11'h05C, d, lat);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL cnt_clear_on_read: got %h required 0", d); end
    axi_read(11'h04C, d, lat);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL cnt_ch0_idle: got %h required 0", d); end
    for (int i = 0; i < 3; i++) begin
      sync_event_i = 2'b10; tick(); sync_event_i = 2'b00; tick();
    end
    axi.araddr = 11'h05C; axi.arvalid = 1'b1;
    tick(); axi.arvalid = 1'b0; sync_event_i = 2'b10;
    tick(); sync_event_i = 2'b00;
    n_checks++;
    if ({axi.rvalid, axi.rdata} !== {1'b1, 32'd3}) begin
      n_fail++; $display("FAIL cnt_coincident_data: got rvalid=%b rdata=%h required 1/3", axi.rvalid, axi.rdata);
    end
    axi.rready = 1'b1; tick(); axi.rready = 1'b0;
    axi_read(11'h05C, d, lat);
    n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL cnt_coincident_next: got %h required 1", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d; int lat; logic [1:0] r;
    axi_write(11'h01C, 32'h3, r);
    axi_write(11'h018, 32'h2, r);
    repeat (2) tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b required 0", irq_o); end
    sync_event_i = 2'b01; tick(); sync_event_i = 2'b00; repeat (2) tick();
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_masked_ch0: got %b required 0", irq_o); end
    axi_read(11'h01C, d, lat);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL irq_status_ch0: got %h required 1", d); end
    sync_event_i = 2'b10; tick(); sync_event_i = 2'b00;
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_registered_lag: got %b required 0", irq_o); end
    tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_ch1: got %b required 1", irq_o); end
    axi_write(11'h01C, 32'h2, r);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b required 0", irq_o); end
    sync_event_i = 2'b10; tick(); sync_event_i = 2'b00; repeat (2) tick();
    axi.awaddr = 11'h01C; axi.wdata = 32'h2; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick(); axi.awvalid = 1'b0; axi.wvalid = 1'b0; sync_event_i = 2'b10;
    tick(); sync_event_i = 2'b00;
    n_checks++; if (axi.bvalid !== 1'b1) begin n_fail++; $display("FAIL irq_w1c_bvalid: got %b required 1", axi.bvalid); end
    axi.bready = 1'b1; tick(); axi.bready = 1'b0;
    repeat (2) tick();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_w1c_vs_event: got %b required 1", irq_o); end
    axi_read(11'h01C, d, lat);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL irq_status_both: got %h required 3", d); end
  endtask

  task automatic test_read_stall();
    logic [1:0] r;
    axi_write(11'h010, 32'h1234_5678, r);
    axi.araddr = 11'h010; axi.arvalid = 1'b1;
    tick(); axi.arvalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({axi.rvalid, axi.arready, axi.rdata} !== {2'b10, 32'h1234_5678}) begin
        n_fail++;
        $display("FAIL read_stall_%0d: got rvalid=%b arready=%b rdata=%h required 1/0/12345678",
                 i, axi.rvalid, axi.arready, axi.rdata);
      end
      tick();
    end
    axi.rready = 1'b1; tick(); axi.rready = 1'b0;
    n_checks++;
    if ({axi.arready, axi.rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL arready_reassert: got arready=%b rvalid=%b required 1/0", axi.arready, axi.rvalid);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d; int lat;
    axi.awaddr = 11'h014; axi.wdata = 32'hCAFE_F00D; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick();
    #2 reset_ni = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    #1;
    n_checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, axi.rdata, ctrl_o, irq_o} !== '0) begin
      n_fail++;
      $display("FAIL mid_write_reset_outputs: got aw%b w%b ar%b b%b r%b rdata=%h ctrl=%h irq=%b, required all 0",
               axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, axi.rdata, ctrl_o, irq_o);
    end
    @(negedge clk); reset_ni = 1'b1;
    tick();
    axi_read(11'h014, d, lat);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL aborted_write_ctrl: got %h required 0", d); end
    n_checks++; if (ctrl_o !== 32'h0) begin n_fail++; $display("FAIL aborted_write_ctrl_o: got %h required 0", ctrl_o); end
  endtask

  initial begin
    reset_ni = 1'b0;
    fs_state_i = '0; N_id_2_i = '0; N_id_i = '0; sync_event_i = '0;
    axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = 4'hF;
    axi.bready = 1'b0; axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b0;
    test_reset();
    test_id_regs();
    test_ctrl_w_first();
    test_ro_discard();
    test_status_inputs();
    test_sync_cnt();
    test_irq();
    test_read_stall();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
